// File: rtl/divisor_secuencial_pkg.sv
// Shared constants for the sequential divider and the control unit.
// Holds the default operand width, the divider state encoding and a helper
// that decodes the states in which the pipeline must stall.
package divisor_secuencial_pkg;

  localparam int ANCHO = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2
  } estado_t;

  // The divider is busy in every state except IDLE.
  function automatic logic es_ocupado(input estado_t e);
    return (e == DIVIDE) || (e == FIX);
  endfunction

endpackage

// File: rtl/restador_div.sv
// Combinational ANCHO+1-bit trial subtractor for the restoring divider.
// Ports:
//   minuendo    - shifted partial remainder (ANCHO+1 bits)
//   sustraendo  - zero-extended divisor magnitude (ANCHO+1 bits)
//   diferencia  - low ANCHO bits of minuendo - sustraendo
//   no_negativo - 1 when the difference is >= 0 (trial subtraction succeeds)
module restador_div #(
  parameter int ANCHO = 32
) (
  input  logic [ANCHO:0]   minuendo,
  input  logic [ANCHO:0]   sustraendo,
  output logic [ANCHO-1:0] diferencia,
  output logic             no_negativo
);

  logic [ANCHO:0] dif_completa;

  // Both operands are below 2^(ANCHO+1) and the divisor below 2^ANCHO, so the
  // ANCHO+1-bit result never wraps: its MSB is a reliable sign bit.
  always_comb begin
    dif_completa = minuendo - sustraendo;
    diferencia   = dif_completa[ANCHO-1:0];
    no_negativo  = ~dif_completa[ANCHO];
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   start       - request a division (honoured only in IDLE)
//   con_signo   - 1 = signed (DIV), 0 = unsigned (DIVU)
//   a, b        - dividend and divisor, sampled with start
//   busy        - high while a division is in flight
//   done        - one-cycle pulse when cociente/resto/div_cero update
//   cociente    - quotient (LO), held until the next done
//   resto       - remainder (HI), held until the next done
//   div_cero    - divisor was zero in the last completed operation
module divisor_secuencial #(
  parameter int ANCHO = divisor_secuencial_pkg::ANCHO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             con_signo,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] resto,
  output logic             div_cero
);

  import divisor_secuencial_pkg::*;

  localparam int CW = $clog2(ANCHO);

  function automatic logic [ANCHO-1:0] negar(input logic [ANCHO-1:0] v);
    return ~v + {{(ANCHO-1){1'b0}}, 1'b1};
  endfunction

  estado_t          estado, estado_sig;
  logic [CW-1:0]    contador;

  // Iteration datapath: partial remainder, dividend/quotient shift register,
  // divisor magnitude and the per-operation fix-up information.
  logic [ANCHO-1:0] rem, quot, divisor, a_raw;
  logic             signo_q, signo_r, zero_b;

  logic [ANCHO-1:0] mag_a, mag_b;
  logic [ANCHO:0]   desplazado;
  logic [ANCHO-1:0] diferencia;
  logic             no_negativo;

  // Magnitudes only differ from the raw operands in signed mode.
  always_comb begin
    mag_a = (con_signo && a[ANCHO-1]) ? negar(a) : a;
    mag_b = (con_signo && b[ANCHO-1]) ? negar(b) : b;
  end

  // {rem, quot} shifted left by one: the dividend MSB enters the remainder.
  assign desplazado = {rem, quot[ANCHO-1]};

  restador_div #(.ANCHO(ANCHO)) u_restador (
    .minuendo    (desplazado),
    .sustraendo  ({1'b0, divisor}),
    .diferencia  (diferencia),
    .no_negativo (no_negativo)
  );

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (start) estado_sig = DIVIDE;
      DIVIDE:  if (contador == CW'(ANCHO - 1)) estado_sig = FIX;
      FIX:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  assign busy = es_ocupado(estado);

  // Control state and architecturally visible results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      contador <= '0;
      done     <= 1'b0;
      cociente <= '0;
      resto    <= '0;
      div_cero <= 1'b0;
    end else begin
      estado <= estado_sig;
      done   <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) contador <= '0;
        end
        DIVIDE: begin
          contador <= contador + 1'b1;
        end
        FIX: begin
          done     <= 1'b1;
          div_cero <= zero_b;
          // Division by zero reports all-ones and the untouched dividend,
          // independent of the sign fix-up.
          if (zero_b) begin
            cociente <= '1;
            resto    <= a_raw;
          end else begin
            cociente <= signo_q ? negar(quot) : quot;
            resto    <= signo_r ? negar(rem) : rem;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on start
  // before being consumed.
  always_ff @(posedge clk) begin
    case (estado)
      IDLE: begin
        if (start) begin
          rem     <= '0;
          quot    <= mag_a;
          divisor <= mag_b;
          a_raw   <= a;
          signo_q <= con_signo & (a[ANCHO-1] ^ b[ANCHO-1]);
          signo_r <= con_signo & a[ANCHO-1];
          zero_b  <= (b == '0);
        end
      end
      DIVIDE: begin
        rem  <= no_negativo ? diferencia : desplazado[ANCHO-1:0];
        quot <= {quot[ANCHO-2:0], no_negativo};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        reset, start, con_signo;
  logic [31:0] a, b, cociente, resto;
  logic        busy, done, div_cero;

  always #5 clk = ~clk;

  divisor_secuencial #(.ANCHO(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .con_signo (con_signo),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .cociente  (cociente),
    .resto     (resto),
    .div_cero  (div_cero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } esperado_t;

  esperado_t cola[$];
  esperado_t e_mon;
  int cyc = 0;
  int total = 0;
  int pasadas = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pasadas++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nombre, act, exp, cyc);
  endtask

  // Reference: C-style truncating division on plain integers.
  function automatic esperado_t modelo(input logic cs, input logic [31:0] av, input logic [31:0] bv);
    esperado_t e;
    longint sa, sb;
    e.cyc = 0;
    if (bv == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = av; e.dz = 1'b1;
    end else if (!cs) begin
      e.q = av / bv; e.r = av % bv; e.dz = 1'b0;
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      e.q = 32'(sa / sb); e.r = 32'(sa % sb); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called one time unit after a rising edge; done is due 34 cycles later.
  task automatic emitir(input logic cs, input logic [31:0] av, input logic [31:0] bv);
    esperado_t e;
    e = modelo(cs, av, bv);
    e.cyc = cyc + 34;
    cola.push_back(e);
    start = 1'b1; con_signo = cs; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; con_signo = 1'($urandom);
  endtask

  // Waits for done, checking busy meanwhile; optionally re-pulses start
  // while busy (must be ignored).
  task automatic esperar_done(input int inyectar);
    bit visto = 1'b0;
    for (int i = 1; i <= 40 && !visto; i++) begin
      if (done) visto = 1'b1;
      else begin
        chk("busy_en_curso", {31'd0, busy}, 32'd1);
        if (i == inyectar) begin
          start = 1'b1; a = $urandom; b = $urandom; con_signo = 1'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (!visto) begin
      total++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
      cola.delete();
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (cola.size() == 0) begin
        total++;
        $display("FAIL done_inesperado: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        e_mon = cola.pop_front();
        chk("cociente", cociente, e_mon.q);
        chk("resto", resto, e_mon.r);
        chk("div_cero", {31'd0, div_cero}, {31'd0, e_mon.dz});
        chk("ciclo_done", cyc, e_mon.cyc);
        chk("busy_en_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; con_signo = 1'b0; a = '0; b = '0;
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_cociente", cociente, 32'd0);
    chk("reset_resto", resto, 32'd0);
    chk("reset_div_cero", {31'd0, div_cero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    emitir(1'b0, 32'd100, 32'd7);                 esperar_done(10);
    emitir(1'b1, 32'hFFFF_FFF9, 32'd2);           esperar_done(0);
    emitir(1'b1, 32'd7, 32'hFFFF_FFFE);           esperar_done(0);
    emitir(1'b0, 32'hFFFF_FFFF, 32'd1);           esperar_done(0);
    emitir(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   esperar_done(0);
    emitir(1'b0, 32'h1234_5678, 32'd0);           esperar_done(0);
    emitir(1'b1, 32'h1234_5678, 32'd0);           esperar_done(5);
    emitir(1'b1, 32'hFFFF_FF9C, 32'd7);           esperar_done(0);

    // Asynchronous reset in the middle of an operation.
    emitir(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_cociente", cociente, 32'd0);
    chk("abort_resto", resto, 32'd0);
    chk("abort_div_cero", {31'd0, div_cero}, 32'd0);
    cola.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      chk("sin_done_tras_abort", {31'd0, done}, 32'd0);
    end
    emitir(1'b0, 32'd1000, 32'd3);                esperar_done(0);

    // Randomized operations, mostly back-to-back.
    for (int n = 0; n < 1500; n++) begin
      logic        cs;
      logic [31:0] av, bv;
      int          sel, iny;
      cs  = 1'($urandom);
      av  = $urandom;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       bv = 32'd0;
        1, 2:    bv = 32'($urandom_range(1, 15));
        3:       bv = -32'($urandom_range(1, 15));
        4:       bv = 32'($urandom) >> $urandom_range(0, 31);
        default: bv = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) av = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) av = av >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      iny = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0;
      emitir(cs, av, bv);
      esperar_done(iny);
    end

    @(negedge clk); #1;
    chk("cola_vacia", cola.size(), 32'd0);

    $display("%0d/%0d checks passed", pasadas, total);
    $finish;
  end

endmodule
